// File: rtl/chon_xung_tham_so.sv
// Selectable-rate clock-enable / pulse generator: channel k runs at BASE_HZ*2^k,
// with rate and mode changes accepted only at the end of a full output period.
module chon_xung_tham_so #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BASE_HZ = 1,
  parameter int unsigned SEL_W   = 2
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             E,
  input  logic [SEL_W-1:0] S,
  input  logic             M,
  output logic             clko,
  output logic             tick,
  output logic [SEL_W-1:0] S_act
);

  localparam int unsigned     N       = 2 ** SEL_W;
  localparam longint unsigned DIV_MAX = (64'(2) * 64'(BASE_HZ)) << (N - 1);
  localparam int unsigned     H0      = CLK_HZ / (2 * BASE_HZ);
  localparam longint unsigned H_LAST  = 64'(CLK_HZ) / DIV_MAX;
  localparam int unsigned     CNT_W   = (H0 > 1) ? $clog2(H0) : 1;

  if ((64'(CLK_HZ) % DIV_MAX) != 64'd0) begin : g_bad_div
    $error("chon_xung_tham_so: CLK_HZ must be divisible by 2*BASE_HZ*2^(N-1)");
  end
  if (H_LAST < 64'd1) begin : g_bad_half
    $error("chon_xung_tham_so: fastest channel needs a half period of at least 1 cycle");
  end

  // Terminal count of a half period; the divisibility check makes the shift exact.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [SEL_W-1:0] k);
    int unsigned h;
    h = H0 >> k;
    return CNT_W'(h - 1);
  endfunction

  logic [CNT_W-1:0] cnt,   cnt_nx;
  logic             phase, phase_nx;
  logic             run,   run_nx;
  logic             mode,  mode_nx;
  logic [SEL_W-1:0] sel_nx;
  logic             tick_nx;
  logic             clko_nx;

  // run delays counting by one edge after E rises, so the first low phase is a full H.
  always_comb begin
    cnt_nx   = cnt;
    phase_nx = phase;
    run_nx   = run;
    sel_nx   = S_act;
    mode_nx  = mode;
    tick_nx  = 1'b0;
    if (!E) begin
      cnt_nx   = '0;
      phase_nx = 1'b0;
      run_nx   = 1'b0;
      sel_nx   = S;
      mode_nx  = M;
    end else if (!run) begin
      run_nx = 1'b1;
    end else if (cnt == last_cnt(S_act)) begin
      cnt_nx   = '0;
      phase_nx = ~phase;
      if (!phase) begin
        tick_nx = 1'b1;
      end else begin
        sel_nx  = S;
        mode_nx = M;
      end
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end

  // At a period boundary both candidates are 0, so the mode switch cannot glitch.
  always_comb begin
    clko_nx = mode_nx ? tick_nx : phase_nx;
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
      run   <= 1'b0;
      mode  <= 1'b0;
      S_act <= '0;
      tick  <= 1'b0;
      clko  <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      phase <= phase_nx;
      run   <= run_nx;
      mode  <= mode_nx;
      S_act <= sel_nx;
      tick  <= tick_nx;
      clko  <= clko_nx;
    end
  end

endmodule

// File: doc/chon_xung_tham_so.md
# chon_xung_tham_so

Parametrised, glitch-free clock-enable and pulse generator. Divides the system clock into 2^SEL_W selectable output rates, with rate k = BASE_HZ·2^k. Rate and mode changes take effect only at an output-period boundary. It replaces the fixed 4-way pulse selector wherever a slow visible clock or tick is needed (LED blink, counter stepping, display scan) and adds a single-cycle tick mode plus an active-selection readback.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- BASE_HZ, 1, output frequency of selection 0 in Hz.
- SEL_W, 2, selection width; number of channels N = 2^SEL_W.
- clki  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- E  input  1  enable; 0 holds the block idle.
- S  input  SEL_W  requested rate; channel k gives BASE_HZ·2^k.
- M  input  1  mode: 0 = 50 % square wave, 1 = one-clki-cycle pulse per period.
- clko  output  1  selected output (registered).
- tick  output  1  one-cycle strobe at the start of every output high phase (registered).
- S_act  output  SEL_W  selection currently in effect.

## Operation
- Half period H(k) = CLK_HZ / (2·BASE_HZ·2^k) clki cycles. The elaboration check fails with $error if CLK_HZ is not divisible by 2·BASE_HZ·2^(N-1), or if H(N-1) < 1.
- Counter width CNT_W = $clog2(H(0)), minimum 1. The counter is unsigned, never exceeds H(S_act)-1 and never overflows.
- State: cnt, phase (0 = low half, 1 = high half), S_act, M_act.
- Idle (E=0): cnt=0, phase=0, clko=0, tick=0. S_act←S and M_act←M every cycle.
- Run (E=1): cnt increments each cycle. When cnt == H(S_act)-1: cnt←0 and phase toggles.
  - Phase 0→1: tick←1 for one cycle.
  - Phase 1→0 (end of a full period): S_act←S, M_act←M. This is the only point at which a change is accepted while running.
- clko: M_act=0 → clko = phase. M_act=1 → clko = tick (high one cycle per period 2·H).
- E falling mid-period: the next edge forces the idle state. A truncated high phase is permitted; E is a hard gate.
- E rising: counting starts from cnt=0, phase=0, using the S/M sampled while idle.
- S or M changing several times within one period: only the value present on the boundary edge is used.
- H(k)=1 (fastest channel at the limit): phase toggles every cycle, giving clko at clki/2. In pulse mode clko is high 1 cycle in 2.

## Timing
- Reset values: clko=0, tick=0, S_act=0, internal cnt=0, phase=0, M_act=0. Reset applies immediately on rst_n low and is released synchronously at the first clki edge with rst_n high.
- Latency from E rise: if E is first sampled high at edge t0, the first rising clko/tick occurs at edge t0+H(S_act)-1+1, i.e. H cycles after t0.
- Square mode: high for exactly H cycles, low for exactly H cycles, period 2H. No runt pulses on S/M change while E=1.
- Pulse mode: tick and clko coincide; one high cycle every 2H cycles.
- A new S/M becomes visible on S_act one cycle after the period-boundary edge. The new period starts low at that edge.
- There are no combinational paths from inputs to outputs.

## Test plan
Use CLK_HZ=16, BASE_HZ=1, SEL_W=2, so H = 8, 4, 2, 1.
- Reset plus idle: rst_n=0 mid-run → clko=tick=0 and S_act=0 immediately. With E=0 and S=2, S_act=2 after one edge and clko stays 0.
- Square sweep: E=1, M=0, S=0..3, held 64 cycles each → clko periods of 16, 8, 4, 2 cycles at exactly 50 % duty, with one tick per rising edge.
- Glitch-free switch: S=0 running; set S=3 at cnt=3 of the high phase → the high phase still lasts 8 cycles. The next period is 2 cycles, and S_act changes to 3 only at the period end.
- Pulse mode: M=1, S=1 → clko is high exactly 1 cycle every 8 cycles and equals tick. Toggle M mid-period → the change applies at the next period boundary.
- Enable gating: E dropped during a high phase → clko=0 on the next edge. E raised again → the first rising clko comes H cycles after E is sampled high.
- Rapid S churn: S toggles 0↔3 every cycle inside one period → S_act takes the value present at the boundary edge, and clko shows no pulse shorter than H(S_act).
